// File: rtl/regfile_write_arbiter_if.sv
// Handshake and write-port bundle between the two write-back requesters,
// the arbiter and the register file write port.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              hold;
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              conflict;

  // Requester / register-file side
  modport master (
    output hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wrEn, wrAddr, wrData, conflict
  );

  // Arbiter side
  modport slave (
    input  hold, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wrEn, wrAddr, wrData, conflict
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port between
// the ALU result (A) and load result (B) requesters. The granted write is
// registered onto wrEn/wrAddr/wrData; writes to register 0 complete the
// handshake but never raise wrEn.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_write_arbiter_if.slave bus
);

  logic              pri;        // 0: A wins next contest, 1: B wins
  logic              grant_a;
  logic              grant_b;
  logic              contested;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Grant selection; nothing is granted during reset or while held
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    contested = bus.a_valid & bus.b_valid & ~bus.hold & ~rst;
    if (!rst && !bus.hold) begin
      if (bus.a_valid && (!bus.b_valid || !pri))
        grant_a = 1'b1;
      else if (bus.b_valid)
        grant_b = 1'b1;
    end
  end

  // Winner's write payload
  always_comb begin
    win_addr = grant_b ? bus.b_addr : bus.a_addr;
    win_data = grant_b ? bus.b_data : bus.a_data;
  end

  assign bus.a_ready = grant_a;
  assign bus.b_ready = grant_b;

  // Priority pointer, write-port register and conflict pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      pri        <= 1'b0;
      bus.wrEn   <= 1'b0;
      bus.wrAddr <= '0;
      bus.wrData <= '0;
      bus.conflict <= 1'b0;
    end else begin
      bus.conflict <= contested;
      // After a contest the pointer names the loser
      if (contested)
        pri <= grant_a;
      if (grant_a || grant_b) begin
        bus.wrEn   <= (win_addr != '0);
        bus.wrAddr <= win_addr;
        bus.wrData <= win_data;
      end else begin
        bus.wrEn <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. The stimulus process checks the
// readies, wrEn and conflict against hand-computed values and queues each
// expected register-file write; a monitor pops and compares on every wrEn.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic rst;

  regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  nvec = 0;
  int  nmis = 0;

  // Monitor: every presented write must match the oldest queued expectation
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (bus.wrEn === 1'b1) begin
      nvec++;
      if (exp_q.size() == 0) begin
        nmis++;
        $display("FAIL write_unexpected: got addr=%0d data=%h, expected none", bus.wrAddr, bus.wrData);
      end else begin
        e = exp_q.pop_front();
        if (bus.wrAddr !== e.addr || bus.wrData !== e.data) begin
          nmis++;
          $display("FAIL write_payload: got addr=%0d data=%h, expected addr=%0d data=%h",
                   bus.wrAddr, bus.wrData, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One cycle: drive inputs, check readies, queue the expected write,
  // then check wrEn and conflict after the edge.
  task automatic step(input string name,
                      input logic r, input logic h,
                      input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic ear, input logic ebr,
                      input logic een, input logic econf);
    wr_t w;
    rst         = r;
    bus.hold    = h;
    bus.a_valid = av;
    bus.a_addr  = aa;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_addr  = ba;
    bus.b_data  = bd;
    #1;
    chk({name, "_a_ready"}, {31'd0, bus.a_ready}, {31'd0, ear});
    chk({name, "_b_ready"}, {31'd0, bus.b_ready}, {31'd0, ebr});
    if (een) begin
      w.addr = ear ? aa : ba;
      w.data = ear ? ad : bd;
      exp_q.push_back(w);
    end
    @(posedge clk);
    #1;
    chk({name, "_wrEn"},     {31'd0, bus.wrEn},     {31'd0, een});
    chk({name, "_conflict"}, {31'd0, bus.conflict}, {31'd0, econf});
  endtask

  initial begin
    rst = 1'b1;
    bus.hold = 1'b0;
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    @(posedge clk);
    #1;

    // Reset with both requesters valid
    step("rst0", 1, 0, 1, 5'd1, 32'h11, 1, 5'd31, 32'h22, 0, 0, 0, 0);
    step("rst1", 1, 0, 1, 5'd1, 32'h11, 1, 5'd31, 32'h22, 0, 0, 0, 0);
    chk("rst_wrAddr", {27'd0, bus.wrAddr}, 32'd0);
    chk("rst_wrData", bus.wrData, 32'd0);

    // Single requester, then idle
    step("single", 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, 1, 0);
    step("idle0",  0, 0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 0, 0, 0, 0);

    // Round-robin: A, B, A, B (pri ends at 0)
    step("rr0", 0, 0, 1, 5'd1, 32'h11, 1, 5'd31, 32'h22, 1, 0, 1, 1);
    step("rr1", 0, 0, 1, 5'd1, 32'h11, 1, 5'd31, 32'h22, 0, 1, 1, 1);
    step("rr2", 0, 0, 1, 5'd1, 32'h11, 1, 5'd31, 32'h22, 1, 0, 1, 1);
    step("rr3", 0, 0, 1, 5'd1, 32'h11, 1, 5'd31, 32'h22, 0, 1, 1, 1);

    // Register 0 write is accepted but discarded
    step("reg0",  0, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h1234, 0, 1, 0, 0);
    step("idle1", 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,    0, 0, 0, 0);

    // Uncontested B grant leaves pri at 0
    step("bonly", 0, 0, 0, 5'd0, 32'h0, 1, 5'd3, 32'h33, 0, 1, 1, 0);

    // Hold blocks grants and leaves pri untouched; A wins on release (pri -> 1)
    step("hold0", 0, 1, 1, 5'd2, 32'hA2, 1, 5'd4, 32'hB4, 0, 0, 0, 0);
    step("hold1", 0, 1, 1, 5'd2, 32'hA2, 1, 5'd4, 32'hB4, 0, 0, 0, 0);
    step("hold2", 0, 1, 1, 5'd2, 32'hA2, 1, 5'd4, 32'hB4, 0, 0, 0, 0);
    step("rel",   0, 0, 1, 5'd2, 32'hA2, 1, 5'd4, 32'hB4, 1, 0, 1, 1);

    // Reset mid-stream with pri=1: B would win, but reset clears pri
    step("mrst",  1, 0, 1, 5'd6, 32'hA6, 1, 5'd4, 32'hB4, 0, 0, 0, 0);
    chk("mrst_wrAddr", {27'd0, bus.wrAddr}, 32'd0);
    step("post0", 0, 0, 1, 5'd6, 32'hA6, 1, 5'd4, 32'hB4, 1, 0, 1, 1);
    step("post1", 0, 0, 0, 5'd0, 32'h0,  1, 5'd4, 32'hB4, 0, 1, 1, 0);

    // Same-address contest: pri=1 so B first, then A
    step("same0", 0, 0, 1, 5'd7, 32'hAAAA, 1, 5'd7, 32'hBBBB, 0, 1, 1, 1);
    step("same1", 0, 0, 1, 5'd7, 32'hAAAA, 0, 5'd0, 32'h0,    1, 0, 1, 0);
    step("idle2", 0, 0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0,    0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
